// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and build defaults.
package dmem_responder_pkg;

  localparam int unsigned DmemAddrBits = 10;
  localparam int unsigned DmemLatency  = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_responder_array.sv
// Word RAM with synchronous write and registered read; contents are never reset.
module dmem_responder_array #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [1 << ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with LATENCY wait states and a held response.
// Optional misalignment detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DmemAddrBits,
  parameter int unsigned LATENCY   = DmemLatency
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] LoadCnt = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   mis_q;
  logic                   mis_in;
  logic                   accept;
  logic                   ram_we;
  logic [31:0]            ram_rdata;
  logic                   unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = |req_addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits are deliberately dropped so addresses wrap within the array.
  assign unused_addr = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};

  assign accept = req_valid && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[ADDR_BITS+1:2];
        wdata_q <= req_wdata;
        mis_q   <= mis_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = StAccess;
          end else begin
            cnt_d   = LoadCnt;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM output stays stable through RESP because idx_q is frozen and no write can occur.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    ram_we    = (state_q == StAccess) && we_q && !mis_q;
    rsp_err   = rsp_valid && mis_q;
    rsp_rdata = (rsp_valid && !we_q && !mis_q) ? ram_rdata : 32'd0;
  end

  dmem_responder_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: table-driven transactions with a response scoreboard, plus reset corners.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
    bit          early;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        use1 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        rr0, rv0, re0, rr1, rv1, re1;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_BITS (4),
    .LATENCY   (2)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid && !use1),
    .req_ready (rr0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rv0),
    .rsp_ready (rsp_ready && !use1),
    .rsp_rdata (rd0),
    .rsp_err   (re0)
  );

  dmem_responder #(
    .ADDR_BITS (4),
    .LATENCY   (0)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid && use1),
    .req_ready (rr1),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rv1),
    .rsp_ready (rsp_ready && use1),
    .rsp_rdata (rd1),
    .rsp_err   (re1)
  );

  assign req_ready = use1 ? rr1 : rr0;
  assign rsp_valid = use1 ? rv1 : rv0;
  assign rsp_rdata = use1 ? rd1 : rd0;
  assign rsp_err   = use1 ? re1 : re0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    #1;
    req_valid = 1'b0;
    rsp_ready = v.early;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 30);
    chk("latency", 32'(n), use1 ? 32'd2 : 32'd4);
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    for (int i = 0; i < v.hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, e.rdata);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("back_idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b1, 32'h40, 32'h1234, 32'h0, 1'b0, 0, 1'b0};
    vecs[3]  = '{1'b0, 32'h00, 32'h0, 32'h1234, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 1'b0};
    vecs[5]  = '{1'b1, 32'h04, 32'hAAAA0001, 32'h0, 1'b0, 0, 1'b1};
    vecs[6]  = '{1'b0, 32'h04, 32'h0, 32'hAAAA0001, 1'b0, 0, 1'b1};
    vecs[7]  = '{1'b0, 32'h13, 32'h0, AlignChk ? 32'h0 : 32'hDEADBEEF, AlignChk, 0, 1'b0};
    vecs[8]  = '{1'b1, 32'h3C, 32'h66, 32'h0, 1'b0, 0, 1'b0};
    vecs[9]  = '{1'b1, 32'h3E, 32'h77, 32'h0, AlignChk, 0, 1'b0};
    vecs[10] = '{1'b0, 32'h3C, 32'h0, AlignChk ? 32'h66 : 32'h77, 1'b0, 0, 1'b0};

    // Reset held with a live request: nothing may be accepted.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h5A5A5A5A;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Store 0xAA, then reset while a store of 0x55 sits in WAIT.
    run_txn('{1'b1, 32'h8, 32'hAA, 32'h0, 1'b0, 0, 1'b0});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midop_wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_rst_ready", 32'(req_ready), 32'd1);
    chk("midop_rst_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    run_txn('{1'b0, 32'h8, 32'h0, 32'hAA, 1'b0, 0, 1'b0});

    // Zero-latency instance with a misaligned store.
    use1 = 1'b1;
    run_txn('{1'b1, 32'h4, 32'h1111, 32'h0, 1'b0, 0, 1'b0});
    run_txn('{1'b1, 32'h6, 32'hCAFE, 32'h0, AlignChk, 0, 1'b0});
    run_txn('{1'b0, 32'h4, 32'h0, AlignChk ? 32'h1111 : 32'hCAFE, 1'b0, 0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
